// File: rtl/plic_pkg.sv
// Shared address map and ID width for the plic_lite interrupt controller.
package plic_pkg;

  localparam int ID_W = 5;

  localparam logic [11:0] PRIO_BASE = 12'h000;
  localparam logic [11:0] PENDING   = 12'h080;
  localparam logic [11:0] ENABLE    = 12'h100;
  localparam logic [11:0] THRESHOLD = 12'h200;
  localparam logic [11:0] CLAIM     = 12'h204;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: turns a level request into one pending/inflight transaction.
module plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      inflight <= 1'b0;
    end else if (claim) begin
      // claim beats a same-edge gateway set, so the source cannot double-pend
      pending  <= 1'b0;
      inflight <= 1'b1;
    end else begin
      if (irq && !pending && !inflight)
        pending <= 1'b1;
      if (complete && inflight)
        inflight <= 1'b0;
    end
  end

endmodule

// File: rtl/plic_lite.sv
// Small PLIC: MMIO config, per-source gateways, priority arbiter into a registered eip.
module plic_lite
  import plic_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     spo,
  input  logic [NSRC-1:0] irq_src,
  output logic            eip
);

  logic [11:0]       addr;
  logic [PRIO_W-1:0] prio [NSRC];
  logic [NSRC:1]     enable;
  logic [NSRC:1]     irq_q;
  logic [NSRC:1]     pending;
  logic [PRIO_W-1:0] threshold;
  logic [ID_W-1:0]   best_id;
  logic [ID_W-1:0]   best_id_q;
  logic [PRIO_W-1:0] best_prio;
  logic              claim_hit;
  logic              cmpl_hit;
  logic              unused_bits;

  assign addr        = {a[11:2], 2'b00};
  assign claim_hit   = re && (addr == CLAIM) && (best_id_q != '0);
  assign cmpl_hit    = we && (addr == CLAIM);
  assign unused_bits = ^{a[1:0], d};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) prio[i] <= '0;
      enable    <= '0;
      threshold <= '0;
      irq_q     <= '0;
      best_id_q <= '0;
      eip       <= 1'b0;
    end else begin
      irq_q     <= irq_src;
      best_id_q <= best_id;
      eip       <= (best_id != '0);
      if (we) begin
        for (int i = 1; i <= NSRC; i++)
          if (addr == PRIO_BASE + 12'(4 * i)) prio[i-1] <= d[PRIO_W-1:0];
        if (addr == ENABLE)    enable    <= d[NSRC:1];
        if (addr == THRESHOLD) threshold <= d[PRIO_W-1:0];
      end
    end
  end

  // ascending scan with strict '>' keeps the lowest ID on priority ties
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pending[i] && enable[i] && (prio[i-1] > threshold) && (prio[i-1] > best_prio)) begin
        best_prio = prio[i-1];
        best_id   = ID_W'(i);
      end
    end
  end

  always_comb begin
    spo = '0;
    for (int i = 1; i <= NSRC; i++)
      if (addr == PRIO_BASE + 12'(4 * i)) spo = 32'(prio[i-1]);
    if (addr == PENDING)   spo = 32'({pending, 1'b0});
    if (addr == ENABLE)    spo = 32'({enable, 1'b0});
    if (addr == THRESHOLD) spo = 32'(threshold);
    if (addr == CLAIM)     spo = 32'(best_id_q);
  end

  for (genvar g = 1; g <= NSRC; g++) begin : g_src
    plic_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_q[g]),
      .claim    (claim_hit && (best_id_q == ID_W'(g))),
      .complete (cmpl_hit && (d[ID_W-1:0] == ID_W'(g))),
      .pending  (pending[g])
    );
  end

endmodule

// File: doc/plic_lite.md
Name: plic_lite

Overview:
- Small platform-level interrupt controller that arbitrates NSRC external interrupt sources into the single machine external interrupt line (eip) consumed by the CSR/privilege unit.
- Software configures it through a CSR-style word-addressed MMIO port:
  - per-source priority
  - enable mask
  - threshold
  - claim/complete register
- Sits between peripheral IRQ lines and the privilege unit; memory-mapped on the system bus.

Parameters:
- NSRC, 8, number of interrupt sources (IDs 1..NSRC; ID 0 means "none"); legal range 1..31.
- PRIO_W, 3, priority field width; priority 0 = source never interrupts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a  in  12  MMIO byte address (bits [1:0] ignored).
- d  in  32  MMIO write data.
- we  in  1  write strobe, one cycle per access.
- re  in  1  read strobe; needed for claim side effect, one cycle per access.
- spo  out  32  combinational read data for address a.
- irq_src  in  NSRC  level interrupt inputs, bit i-1 = source ID i, synchronous to clk.
- eip  out  1  registered external interrupt request to privilege unit.

Behaviour:
- Address map (unlisted addresses read 0, writes ignored):
  - 0x000+4*i, i=1..NSRC: priority[i] (RW, low PRIO_W bits; upper bits read 0).
  - 0x080: pending bits (RO, bit i = source i, bit 0 reads 0).
  - 0x100: enable bits (RW, bit 0 hardwired 0).
  - 0x200: threshold (RW, PRIO_W bits).
  - 0x204: claim on read, complete on write.
- Reset: all priorities, enable, threshold, pending, inflight = 0; irq_q = 0; best_id_q = 0; eip = 0.
- Input stage: irq_q <= irq_src every cycle (one register).
- Gateway, per source i:
  - Set pending[i] when irq_q[i]=1 && !pending[i] && !inflight[i].
  - On claim of i: clear pending[i], set inflight[i].
  - On complete write with d[4:0]=i && inflight[i]: clear inflight[i].
  - Level still high after complete re-pends on the next cycle.
- Arbiter (combinational over sources, registered result):
  - Candidate i: pending[i] && enable[i] && priority[i] > threshold.
  - best = highest priority; ties go to the lowest ID; none → 0.
  - best_id_q <= best each cycle.
  - eip <= (best != 0).
- Latency:
  - irq_src edge → pending: 2 cycles (irq_q, then pending).
  - pending → eip: 1 cycle; irq_src → eip = 3 cycles.
  - Config write → eip/claim value: 1 cycle.
- Claim (re && a==0x204):
  - spo = best_id_q.
  - If best_id_q != 0, that source is claimed on the same edge.
  - best_id_q == 0: returns 0, no state change.
- Complete (we && a==0x204):
  - ID 0, ID > NSRC, or ID not inflight: ignored silently.
- Simultaneous events:
  - Claim of i and gateway set of i on same edge: claim wins, pending stays 0.
  - Complete of i and irq_q[i]=1 on same edge: inflight cleared; pending set the next cycle.
  - Enable cleared for a pending source: pending retained, eip drops after 1 cycle.
  - we and re on the same cycle: both actions apply.
- eip stays high while any candidate exists; it is not a pulse. Privilege unit samples it through its own interrupt FSM.
- Reset mid-operation clears pending/inflight; sources still high re-pend 2 cycles after reset deasserts.

Decomposition:
- Shared package (plic_pkg):
  - address offset constants: PRIO_BASE, PENDING, ENABLE, THRESHOLD, CLAIM.
  - ID width localparam = 5.
- One sub-module: plic_gateway, one instance per source, holding pending/inflight with set/claim/complete inputs.
- Arbiter tree and MMIO decode stay in the top.

Test Plan:
- Reset, then read all registers → every register reads 0, eip=0.
- prio[3]=2, enable=0x08, threshold=0; pulse irq_src[2] high → eip=1 exactly 3 cycles later; claim read returns 3; pending bit 3 clears; eip=0 the next cycle.
- prio[2]=5, prio[5]=5, prio[6]=7; enable sources 2, 5, 6; assert all three → claims return 6, then 2, then 5.
- threshold=5, prio[4]=5, source 4 asserted → eip stays 0; write threshold=4 → eip=1 one cycle later.
- Source 1 level held high: claim returns 1 → no re-pend while inflight; write complete d=1 → pending[1]=1 the next cycle, eip=1 one cycle after that.
- Write complete d=0, then d=9 (NSRC=8), then d=2 with source 2 not inflight → no state change; claim with nothing pending returns 0.
